mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 10, SHALL give the number of valid word-address bits (memory depth 2^ADDR_BITS = 1024 words).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset, sampled on posedge clk.
REQ-004 p0_req, p1_req  input  1 each  SHALL be the access requests; port 0 = CPU, port 1 = loader/host.
REQ-005 p0_we, p1_we  input  1 each  SHALL select write (1) or read (0).
REQ-006 p0_addr, p1_addr  input  32 each  SHALL be the word addresses.
REQ-007 p0_wdata, p1_wdata  input  32 each  SHALL be the write data.
REQ-008 p0_ack, p1_ack  output  1 each  SHALL be one-cycle completion pulses.
REQ-009 p0_err, p1_err  output  1 each  SHALL flag an out-of-range address; valid only while the matching ack is high.
REQ-010 p0_rdata, p1_rdata  output  32 each  SHALL be the registered read data; valid while the matching ack is high.
REQ-011 m_we  output  1  SHALL drive the memory write_enable.
REQ-012 m_raddr, m_waddr  output  32 each  SHALL drive the memory read_address and write_address.
REQ-013 m_wdata  output  32  SHALL drive the memory data_in.
REQ-014 m_rdata  input  32  SHALL receive the memory data_out, which is a combinational read.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, RESP. Transitions:
- IDLE -> ACCESS when any req is high.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-016 In IDLE with any req high, the arbiter SHALL latch the winner index, we, addr and wdata into internal registers at the clock edge.
REQ-017 In ACCESS, m_raddr and m_waddr SHALL both equal the latched addr, and m_wdata SHALL equal the latched wdata.
REQ-018 In ACCESS, m_we SHALL equal latched we AND in-range; m_we SHALL be 0 in all other states.
REQ-019 A request is in-range when addr[31:ADDR_BITS] == 0.
REQ-020 At the edge leaving ACCESS, the winner's rdata register SHALL capture m_rdata for an in-range read, and 0 for a write or an out-of-range access.
REQ-021 In RESP, the winner's ack SHALL be 1 for exactly one cycle; err SHALL be 1 if the access was out of range.
REQ-022 Latency SHALL be: req seen in IDLE at cycle N -> memory access in cycle N+1 -> ack in cycle N+2. Peak throughput SHALL be one transaction per 3 cycles.
REQ-023 With both reqs high in IDLE, the port not granted last SHALL win (round-robin); the last-granted pointer SHALL update on each grant.
REQ-024 A request dropped after being latched SHALL still complete, including any write, and SHALL still be acked.
REQ-025 A requester SHALL hold req high until ack. A req still high in the cycle after ack SHALL be treated as a new request.
REQ-026 A req dropped while IDLE before being latched SHALL cause no access.
REQ-027 The non-granted ack and err SHALL stay 0; its rdata SHALL hold its previous value.

Reset
REQ-028 On rst, the FSM SHALL enter IDLE. The following SHALL reset to 0: all acks, all errs, all rdata, m_we, m_raddr, m_waddr, m_wdata.
REQ-029 On rst, the last-granted pointer SHALL be set so that port 0 wins the first tie.
REQ-030 rst asserted in ACCESS or RESP SHALL abort the transaction: no ack, and no write at or after the reset edge.

Configuration
REQ-031 With MEM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win ties and the round-robin pointer SHALL be removed. Without the macro, arbitration SHALL be round-robin per REQ-023.

Verification
REQ-032 Single read: p0 reads addr 2 while mem[2]=8 -> p0_ack at cycle N+2 with p0_rdata=8 and p0_err=0; m_we stays 0 throughout.
REQ-033 Write then read: p1 writes 0x1234 to addr 5, then p0 reads addr 5 -> m_we high for exactly one cycle; p0_rdata=0x1234.
REQ-034 Tie sequence: both reqs held high for 4 transactions -> grants p0, p1, p0, p1 (round-robin); with MEM_ARB_FIXED_PRIO_EN defined -> p0 four times.
REQ-035 Out-of-range: p0 writes addr 1024 -> m_we stays 0; p0_ack=1 and p0_err=1 with p0_rdata=0; memory contents unchanged.
REQ-036 Reset in ACCESS during a p1 write to addr 7 -> no p1_ack; mem[7] keeps -3; state returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port, combinational-read memory.
// Round-robin on ties by default; define MEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority.
module mem_arbiter #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p1_wdata,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic        p0_err,
    output logic        p1_err,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        m_we,
    output logic [31:0] m_raddr,
    output logic [31:0] m_waddr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nxt;
    logic win, l_we, gnt, in_range, start;
    logic [31:0] l_addr, l_wdata, rd;
    assign start = state == IDLE && (p0_req || p1_req);
    assign in_range = (l_addr >> ADDR_BITS) == 32'd0;
    assign rd = (in_range && !l_we) ? m_rdata : 32'd0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    assign gnt = p1_req && !p0_req;
`else
    logic last;
    // last holds the most recently granted port; the other one wins a tie
    assign gnt = (p0_req && p1_req) ? !last : p1_req;
    always_ff @(posedge clk)
        if (rst) last <= 1'b1;
        else if (start) last <= gnt;
`endif
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_comb
        state_nxt = state == IDLE ? (start ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            win      <= 1'b0;
            l_we     <= 1'b0;
            l_addr   <= '0;
            l_wdata  <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            if (start) begin
                win     <= gnt;
                l_we    <= gnt ? p1_we : p0_we;
                l_addr  <= gnt ? p1_addr : p0_addr;
                l_wdata <= gnt ? p1_wdata : p0_wdata;
            end
            if (state == ACCESS) begin
                if (win) p1_rdata <= rd;
                else p0_rdata <= rd;
            end
        end
    end
    // rst gates the strobes so an aborted transaction neither writes nor acks on the reset edge
    always_comb begin
        m_we   = state == ACCESS && l_we && in_range && !rst;
        p0_ack = state == RESP && !win && !rst;
        p1_ack = state == RESP && win && !rst;
        p0_err = p0_ack && !in_range;
        p1_err = p1_ack && !in_range;
    end
    assign m_raddr = l_addr;
    assign m_waddr = l_addr;
    assign m_wdata = l_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a timestamp-based transaction model.
module tb_mem_arbiter;
    localparam int AB = 10;
    logic clk = 0, rst = 1;
    logic p0_req = 0, p1_req = 0, p0_we = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
    logic p0_ack, p1_ack, p0_err, p1_err, m_we;
    logic [31:0] p0_rdata, p1_rdata, m_raddr, m_waddr, m_wdata, m_rdata;
    logic [31:0] mem [1024] = '{default: 32'd0};
    int total = 0, bad = 0, we_cnt = 0;
    bit a0 = 0, a1 = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_err(p0_err), .p1_err(p1_err),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .m_we(m_we), .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    assign m_rdata = mem[m_raddr[AB-1:0]];
    always @(posedge clk) if (m_we) mem[m_waddr[AB-1:0]] <= m_wdata;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", n, a, e);
        end
    endtask

    function automatic bit inr(input logic [31:0] a);
        return (a >> AB) == 32'd0;
    endfunction

    // Model: a transaction granted at the end of cycle tg is accessed in tg+1, acked in tg+2,
    // and the arbiter is free for a new grant from cycle tg+3 on.
    longint cyc = 0, tg = -10;
    bit tv = 0, tp = 0, twe = 0, rr_last = 1;
    logic [31:0] ta = 0, twd = 0;
    logic [31:0] mref [1024] = '{default: 32'd0};
    logic [31:0] erd [2] = '{32'd0, 32'd0};

    always @(posedge clk) begin
        if (rst) begin
            tv = 0;
            rr_last = 1;
            erd[0] = 0;
            erd[1] = 0;
        end else begin
            if (tv && cyc == tg + 1) begin
                erd[tp] = (!twe && inr(ta)) ? mref[ta[AB-1:0]] : 32'd0;
                if (twe && inr(ta)) mref[ta[AB-1:0]] = twd;
            end
            if ((!tv || cyc >= tg + 3) && (p0_req || p1_req)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                tp = !p0_req;
`else
                tp = (p0_req && p1_req) ? !rr_last : p1_req;
`endif
                rr_last = tp;
                twe = tp ? p1_we : p0_we;
                ta  = tp ? p1_addr : p0_addr;
                twd = tp ? p1_wdata : p0_wdata;
                tg = cyc;
                tv = 1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit acc, rsp;
        acc = !rst && tv && cyc == tg + 1;
        rsp = !rst && tv && cyc == tg + 2;
        chk1("p0_ack", p0_ack, rsp && !tp);
        chk1("p1_ack", p1_ack, rsp && tp);
        if (rsp && !tp) chk1("p0_err", p0_err, !inr(ta));
        if (rsp && tp) chk1("p1_err", p1_err, !inr(ta));
        chk1("m_we", m_we, acc && twe && inr(ta));
        if (acc) begin
            chk("m_raddr", m_raddr, ta);
            chk("m_waddr", m_waddr, ta);
            chk("m_wdata", m_wdata, twd);
        end
        chk("p0_rdata", p0_rdata, erd[0]);
        chk("p1_rdata", p1_rdata, erd[1]);
    end

    always @(negedge clk) begin
        a0 = p0_ack;
        a1 = p1_ack;
        if (m_we) we_cnt++;
    end

    task automatic txn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output bit er, output int lat);
        if (p) begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; end
        else begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; end
        rd = '0;
        er = 0;
        lat = 21;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (p ? p1_ack : p0_ack) begin
                lat = k;
                rd = p ? p1_rdata : p0_rdata;
                er = p ? p1_err : p0_err;
                break;
            end
        end
        chk1("ack_seen", lat <= 20, 1'b1);
        @(posedge clk); #1;
        p0_req = 0;
        p1_req = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        return ($urandom_range(7) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(31));
    endfunction

    initial begin
        logic [31:0] rd, m0;
        bit er;
        int lat, w0, n;
        logic [3:0] got;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_p0_ack", p0_ack, 1'b0);
        chk1("rst_p1_ack", p1_ack, 1'b0);
        chk1("rst_m_we", m_we, 1'b0);
        chk("rst_m_raddr", m_raddr, 32'd0);
        chk("rst_m_waddr", m_waddr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        @(posedge clk); #1 rst = 0;

        txn(1, 1, 32'd2, 32'd8, rd, er, lat);
        w0 = we_cnt;
        txn(0, 0, 32'd2, 32'd0, rd, er, lat);
        chk("rd2_data", rd, 32'd8);
        chk1("rd2_err", er, 1'b0);
        chk("rd2_latency", 32'(lat), 32'd3);
        chk("rd2_no_write", 32'(we_cnt - w0), 32'd0);

        w0 = we_cnt;
        txn(1, 1, 32'd5, 32'h1234, rd, er, lat);
        chk("wr5_we_pulses", 32'(we_cnt - w0), 32'd1);
        txn(0, 0, 32'd5, 32'd0, rd, er, lat);
        chk("rd5_data", rd, 32'h1234);

        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        p0_we = 0; p0_addr = 2; p1_we = 0; p1_addr = 5;
        p0_req = 1; p1_req = 1;
        n = 0;
        got = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                got[n] = p1_ack;
                n++;
            end
        end
        chk("tie_count", 32'(n), 32'd4);
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk("tie_order", {28'd0, got}, 32'h0);
`else
        chk("tie_order", {28'd0, got}, 32'ha);
`endif
        @(posedge clk); #1;
        p0_req = 0;
        p1_req = 0;

        m0 = mem[0];
        w0 = we_cnt;
        txn(0, 1, 32'd1024, 32'hdead, rd, er, lat);
        chk1("oor_err", er, 1'b1);
        chk("oor_rdata", rd, 32'd0);
        chk("oor_no_write", 32'(we_cnt - w0), 32'd0);
        chk("oor_mem0", mem[0], m0);

        txn(1, 1, 32'd7, 32'hfffffffd, rd, er, lat);
        p1_req = 1; p1_we = 1; p1_addr = 7; p1_wdata = 32'h55;
        @(posedge clk); #1;
        rst = 1;
        p1_req = 0;
        @(posedge clk); #1 rst = 0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (p1_ack) n++;
        end
        chk("abort_no_ack", 32'(n), 32'd0);
        chk("abort_mem7", mem[7], 32'hfffffffd);
        @(posedge clk); #1;
        txn(0, 0, 32'd7, 32'd0, rd, er, lat);
        chk("abort_idle_latency", 32'(lat), 32'd3);
        chk("abort_rd7", rd, 32'hfffffffd);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst = $urandom_range(99) == 0;
            if (p0_req && (a0 || rst || $urandom_range(19) == 0)) p0_req = 0;
            else if (!p0_req && $urandom_range(2) == 0) begin
                p0_req = 1; p0_we = 1'($urandom_range(1)); p0_addr = rnd_addr(); p0_wdata = $urandom;
            end
            if (p1_req && (a1 || rst || $urandom_range(19) == 0)) p1_req = 0;
            else if (!p1_req && $urandom_range(2) == 0) begin
                p1_req = 1; p1_we = 1'($urandom_range(1)); p1_addr = rnd_addr(); p1_wdata = $urandom;
            end
        end
        @(posedge clk); #1;
        rst = 0;
        p0_req = 0;
        p1_req = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
